// File: rtl/if_stage_pip.sv
// if_stage_pip: instruction fetch stage that owns the PC, fetches over valid/ready and
// feeds the IF/ID register through a one-entry skid buffer with branch redirect handling.
module if_stage_pip #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC_IF_out,
  output logic [31:0] instruction_IF_out,
  output logic        valid_IF_out
);
  localparam logic [0:0] S_FETCH   = 1'b0;
  localparam logic [0:0] S_DISCARD = 1'b1;
  logic [0:0]  r_state;
  logic        r_started;
  logic [31:0] r_pc;
  logic [31:0] r_tgt;
  logic [31:0] r_skid_pc;
  logic [31:0] r_skid_instr;
  logic        r_skid_valid;
  logic [31:0] r_if_pc;
  logic [31:0] r_if_instr;
  logic        r_if_valid;
  logic        w_done;
  logic [31:0] w_tgt;
  assign imem_req           = r_started & ~r_skid_valid;
  assign imem_addr          = r_pc;
  assign w_done             = imem_req & imem_ready;
  assign w_tgt              = {branch_target[31:2], 2'b00};
  assign PC_IF_out          = r_if_pc;
  assign instruction_IF_out = r_if_instr;
  assign valid_IF_out       = r_if_valid;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_FETCH;
      r_started    <= 1'b0;
      r_pc         <= RESET_PC;
      r_tgt        <= 32'h0;
      r_skid_pc    <= 32'h0;
      r_skid_instr <= 32'h0;
      r_skid_valid <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_instr   <= NOP_INSTR;
      r_if_valid   <= 1'b0;
    end else begin
      r_started <= 1'b1;
      if (r_state == S_DISCARD) begin
        // an old-address fetch is still in flight; its word is dropped when it lands
        r_if_valid <= 1'b0;
        r_if_instr <= NOP_INSTR;
        if (branch_taken) r_tgt <= w_tgt;
        if (w_done) begin
          r_pc    <= branch_taken ? w_tgt : r_tgt;
          r_state <= S_FETCH;
        end
      end else if (branch_taken) begin
        r_if_valid   <= 1'b0;
        r_if_instr   <= NOP_INSTR;
        r_skid_valid <= 1'b0;
        if (w_done || !imem_req) r_pc <= w_tgt;
        else begin
          r_tgt   <= w_tgt;
          r_state <= S_DISCARD;
        end
      end else if (w_done) begin
        r_pc <= r_pc + 32'd4;
        if (stall) begin
          r_skid_pc    <= r_pc;
          r_skid_instr <= imem_rdata;
          r_skid_valid <= 1'b1;
        end else begin
          r_if_pc    <= r_pc;
          r_if_instr <= imem_rdata;
          r_if_valid <= 1'b1;
        end
      end else if (!stall) begin
        r_if_valid   <= r_skid_valid;
        r_if_instr   <= r_skid_valid ? r_skid_instr : NOP_INSTR;
        r_if_pc      <= r_skid_valid ? r_skid_pc : r_if_pc;
        r_skid_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_if_stage_pip.sv
// tb_if_stage_pip: directed scenarios plus a randomized run checked against a
// program-order stream model (each delivered instruction must be the next expected PC).
module tb_if_stage_pip;
  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b1;
  logic [31:0] imem_rdata;
  logic [31:0] PC_IF_out;
  logic [31:0] instruction_IF_out;
  logic        valid_IF_out;
  int checks = 0;
  int failures = 0;

  if_stage_pip dut (
    .clock(clock), .reset_n(reset_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata), .PC_IF_out(PC_IF_out),
    .instruction_IF_out(instruction_IF_out), .valid_IF_out(valid_IF_out)
  );

  always #5 clock = ~clock;
  assign imem_rdata = imem_addr ^ KEY;

  task automatic tick;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset;
    reset_n = 1'b0; stall = 0; branch_taken = 0; imem_ready = 1;
    #12;
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (imem_addr !== 32'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
    checks++; if (PC_IF_out !== 32'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", PC_IF_out); end
    checks++; if (instruction_IF_out !== NOP) begin failures++; $display("FAIL reset_instr got=%h exp=%h", instruction_IF_out, NOP); end
    checks++; if (valid_IF_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", valid_IF_out); end
  endtask

  task automatic test_stream;
    @(negedge clock); reset_n = 1'b1;
    tick;
    checks++; if (imem_req !== 1'b1 || valid_IF_out !== 1'b0) begin failures++; $display("FAIL stream_edge1 req=%b valid=%b exp req=1 valid=0", imem_req, valid_IF_out); end
    for (int k = 0; k < 2; k++) begin
      tick;
      checks++; if (valid_IF_out !== 1'b1 || PC_IF_out !== 32'(4*k) || instruction_IF_out !== (32'(4*k) ^ KEY))
        begin failures++; $display("FAIL stream_pc%0d got v=%b pc=%h ins=%h exp pc=%h", k, valid_IF_out, PC_IF_out, instruction_IF_out, 32'(4*k)); end
    end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (PC_IF_out !== 32'h4 || valid_IF_out !== 1'b1 || imem_req !== 1'b0)
        begin failures++; $display("FAIL stall_hold%0d pc=%h v=%b req=%b exp pc=4 v=1 req=0", k, PC_IF_out, valid_IF_out, imem_req); end
    end
    stall = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++; if (PC_IF_out !== 32'(8 + 4*k) || valid_IF_out !== 1'b1 || instruction_IF_out !== (32'(8 + 4*k) ^ KEY))
        begin failures++; $display("FAIL stall_release%0d pc=%h v=%b exp pc=%h", k, PC_IF_out, valid_IF_out, 32'(8 + 4*k)); end
    end
  endtask

  task automatic test_branch;
    branch_taken = 1'b1; branch_target = 32'h100;
    tick;
    branch_taken = 1'b0;
    checks++; if (valid_IF_out !== 1'b0 || imem_addr !== 32'h100)
      begin failures++; $display("FAIL branch_flush v=%b addr=%h exp v=0 addr=100", valid_IF_out, imem_addr); end
    tick;
    checks++; if (valid_IF_out !== 1'b1 || PC_IF_out !== 32'h100)
      begin failures++; $display("FAIL branch_target v=%b pc=%h exp v=1 pc=100", valid_IF_out, PC_IF_out); end
  endtask

  task automatic test_discard;
    branch_taken = 1'b1; branch_target = 32'h20;
    tick;
    imem_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      branch_taken = (k == 1 || k == 3);
      branch_target = (k == 1) ? 32'h200 : 32'h300;
      tick;
      checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h20 || valid_IF_out !== 1'b0)
        begin failures++; $display("FAIL discard_wait%0d req=%b addr=%h v=%b exp req=1 addr=20 v=0", k, imem_req, imem_addr, valid_IF_out); end
    end
    branch_taken = 1'b0; imem_ready = 1'b1;
    tick;
    checks++; if (imem_addr !== 32'h300 || valid_IF_out !== 1'b0)
      begin failures++; $display("FAIL discard_drop addr=%h v=%b exp addr=300 v=0", imem_addr, valid_IF_out); end
    tick;
    checks++; if (valid_IF_out !== 1'b1 || PC_IF_out !== 32'h300 || instruction_IF_out !== (32'h300 ^ KEY))
      begin failures++; $display("FAIL discard_next v=%b pc=%h exp v=1 pc=300", valid_IF_out, PC_IF_out); end
  endtask

  task automatic test_branch_stall;
    stall = 1'b1;
    tick;
    checks++; if (imem_req !== 1'b0 || PC_IF_out !== 32'h300)
      begin failures++; $display("FAIL skid_full req=%b pc=%h exp req=0 pc=300", imem_req, PC_IF_out); end
    branch_taken = 1'b1; branch_target = 32'h403;
    tick;
    checks++; if (valid_IF_out !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h400)
      begin failures++; $display("FAIL branch_stall v=%b req=%b addr=%h exp v=0 req=1 addr=400", valid_IF_out, imem_req, imem_addr); end
    stall = 1'b0; branch_taken = 1'b0;
    tick;
    checks++; if (valid_IF_out !== 1'b1 || PC_IF_out !== 32'h400)
      begin failures++; $display("FAIL branch_stall_next v=%b pc=%h exp v=1 pc=400", valid_IF_out, PC_IF_out); end
  endtask

  task automatic test_async_reset;
    tick;
    #2 reset_n = 1'b0;
    #1;
    checks++; if (imem_req !== 1'b0 || imem_addr !== 32'h0 || PC_IF_out !== 32'h0 || instruction_IF_out !== NOP || valid_IF_out !== 1'b0)
      begin failures++; $display("FAIL async_reset req=%b addr=%h pc=%h ins=%h v=%b", imem_req, imem_addr, PC_IF_out, instruction_IF_out, valid_IF_out); end
    @(negedge clock); reset_n = 1'b1;
    tick;
    checks++; if (valid_IF_out !== 1'b0) begin failures++; $display("FAIL async_edge1 v=%b exp 0", valid_IF_out); end
    tick;
    checks++; if (valid_IF_out !== 1'b1 || PC_IF_out !== 32'h0)
      begin failures++; $display("FAIL async_first v=%b pc=%h exp v=1 pc=0", valid_IF_out, PC_IF_out); end
  endtask

  task automatic test_random;
    logic [31:0] exp_pc, p_pc, p_ins, p_addr;
    logic        p_v, p_req;
    int          delivered, bad;
    reset_n = 1'b0; stall = 0; branch_taken = 0; imem_ready = 1;
    #3;
    @(negedge clock); reset_n = 1'b1;
    exp_pc = 32'h0; delivered = 0; bad = 0;
    for (int i = 0; i < 3000; i++) begin
      stall = ($urandom_range(0, 3) == 0);
      branch_taken = ($urandom_range(0, 11) == 0);
      imem_ready = ($urandom_range(0, 9) < 7);
      branch_target = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      p_pc = PC_IF_out; p_ins = instruction_IF_out; p_v = valid_IF_out; p_req = imem_req; p_addr = imem_addr;
      tick;
      if (branch_taken) begin
        checks++; if (valid_IF_out !== 1'b0) begin failures++; bad++; $display("FAIL rnd_flush cyc=%0d v=%b exp 0", i, valid_IF_out); end
        exp_pc = branch_target & ~32'h3;
      end else if (stall) begin
        checks++; if ({PC_IF_out, instruction_IF_out, valid_IF_out} !== {p_pc, p_ins, p_v})
          begin failures++; bad++; $display("FAIL rnd_hold cyc=%0d pc=%h v=%b exp pc=%h v=%b", i, PC_IF_out, valid_IF_out, p_pc, p_v); end
      end else if (valid_IF_out) begin
        checks++; if (PC_IF_out !== exp_pc || instruction_IF_out !== (exp_pc ^ KEY))
          begin failures++; bad++; $display("FAIL rnd_order cyc=%0d pc=%h ins=%h exp pc=%h", i, PC_IF_out, instruction_IF_out, exp_pc); end
        exp_pc = exp_pc + 32'd4;
        delivered++;
      end
      if (!valid_IF_out) begin
        checks++; if (instruction_IF_out !== NOP) begin failures++; bad++; $display("FAIL rnd_nop cyc=%0d ins=%h exp %h", i, instruction_IF_out, NOP); end
      end
      if (p_req && !imem_ready) begin
        checks++; if (imem_addr !== p_addr) begin failures++; bad++; $display("FAIL rnd_addr_stable cyc=%0d addr=%h exp %h", i, imem_addr, p_addr); end
      end
      if (bad > 10) break;
    end
    checks++; if (delivered < 300) begin failures++; $display("FAIL rnd_progress delivered=%0d exp>=300", delivered); end
  endtask

  initial begin
    test_reset;
    test_stream;
    test_stall;
    test_branch;
    test_discard;
    test_branch_stall;
    test_async_reset;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/if_stage_pip.md
# if_stage_pip

Instruction-fetch stage of the pipelined RISC-V core. It sits directly upstream of the decode stage and owns the program counter. It issues word fetches to instruction memory over a valid/ready handshake and delivers {PC, instruction, valid} through the IF/ID pipeline register to decode. It absorbs hazard-unit stalls with a one-entry skid buffer and handles taken-branch redirects, including redirects that arrive while a fetch is still outstanding.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset
- NOP_INSTR, 32'h0000_0013, instruction word driven on bubbles (addi x0,x0,0)

Ports:
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- stall  in  1  hazard unit: hold the IF/ID register
- branch_taken  in  1  redirect from branch resolution; flushes the IF/ID register and the skid buffer
- branch_target  in  32  redirect address, sampled when branch_taken=1
- imem_req  out  1  fetch request valid
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  memory returns imem_rdata for imem_addr this cycle
- imem_rdata  in  32  fetched instruction word
- PC_IF_out  out  32  IF/ID register: PC of the instruction
- instruction_IF_out  out  32  IF/ID register: instruction word
- valid_IF_out  out  1  IF/ID register: entry holds a real instruction

## Operation
- A fetch completes on a rising edge where imem_req=1 and imem_ready=1.
- imem_req = started & ~skid_valid.
  - started is a flop that resets to 0 and sets to 1 on the first edge after reset release.
- imem_addr = pc.
  - Memory requires imem_addr to be stable while imem_req=1 and imem_ready=0.
- State machine, two states:
  - FETCH: normal operation.
  - DISCARD: a redirect arrived with a fetch outstanding; the returning word is dropped.
- FETCH, branch_taken=0:
  - Completion, stall=0, skid empty: IF/ID <= {pc, imem_rdata, 1}; pc <= pc+4.
  - Completion, stall=1: skid <= {pc, imem_rdata}; skid_valid <= 1; pc <= pc+4; IF/ID holds.
  - No completion, stall=0, skid_valid=1: IF/ID <= {skid, 1}; skid_valid <= 0.
  - No completion, stall=0, skid empty: IF/ID valid <= 0; instruction <= NOP_INSTR; PC holds.
  - stall=1, no completion: everything holds.
- FETCH, branch_taken=1 (overrides stall): IF/ID valid <= 0 with NOP_INSTR; skid_valid <= 0.
  - Completion this edge, or no request pending (imem_req=0): pc <= branch_target; stay in FETCH. Any returned data is dropped.
  - imem_req=1 and imem_ready=0: tgt <= branch_target; go to DISCARD; pc is unchanged.
- DISCARD:
  - imem_req=1 with the old address; IF/ID valid <= 0 every edge.
  - branch_taken=1 again: tgt <= branch_target (latest redirect wins).
  - On completion: data dropped; pc <= (branch_taken ? branch_target : tgt); go to FETCH.
- pc wraps modulo 2^32. Bits [1:0] of branch_target are ignored and forced to 0.

## Timing
- Reset (asynchronous, while reset_n=0):
  - pc=RESET_PC; state=FETCH; started=0; skid_valid=0; imem_req=0; imem_addr=RESET_PC.
  - PC_IF_out=0; instruction_IF_out=NOP_INSTR; valid_IF_out=0.
  - Reset asserted mid-fetch abandons the fetch; memory must tolerate a dropped request.
- With a zero-wait memory (imem_ready=1):
  - Edge 1 after release: started=1.
  - Edge 2: IF/ID holds RESET_PC; one instruction per cycle after that.
- Fetch-to-IF/ID latency is one edge after completion, or one edge after the stall clears if the word was skidded.
- Throughput is one instruction per cycle with no stalls and no redirects.
- Redirect penalty:
  - With no fetch outstanding, the target is fetched the cycle after the branch_taken edge.
  - In DISCARD it is fetched the cycle after the dropped completion.
- No instruction is lost or duplicated across any stall/redirect combination.
- The skid holds at most one entry; imem_req=0 while it is full.

## Test plan
- Zero-wait memory, imem_rdata=addr^32'hA5A5_0000, no stall/branch -> from edge 2, IF/ID shows PC 0,4,8,... with matching words, valid=1 every cycle.
- stall=1 for 3 cycles from PC 8 -> IF/ID holds PC 4; skid takes PC 8; imem_req=0; after release IF/ID shows 8 then 12, none dropped.
- branch_taken=1, target 32'h100, while decoding PC 0x10 -> next edge valid=0; fetches resume at 0x100; no 0x14/0x18 reaches IF/ID.
- imem_ready held 0 for 4 cycles at 0x20; branch_taken to 0x200 in cycle 1, then to 0x300 in cycle 3 -> imem_addr stays 0x20 until ready; that word is dropped; next fetch is 0x300.
- branch_taken and stall both 1 with skid full -> skid and IF/ID valid cleared; pc=target.
- reset_n pulsed low mid-stream -> all outputs return to reset values asynchronously; first valid is at RESET_PC two edges after release.
